// File: rtl/busc_register_bank_if.sv
// Bus-side signal bundle for the BUSC register bank: write controls in,
// register contents and status flags out.
interface busc_register_bank_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic [DATA_W-1:0] busc;
  logic [6:0]        wrc;
  logic [3:0]        inc;
  logic              clr_ac;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic [DATA_W-1:0] tr;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] ar;
  logic              ac_z;
  logic              wr_err;

  modport master (
    output en, busc, wrc, inc, clr_ac,
    input  pc, r1, r2, tr, r, ac, ar, ac_z, wr_err
  );

  modport slave (
    input  en, busc, wrc, inc, clr_ac,
    output pc, r1, r2, tr, r, ac, ar, ac_z, wr_err
  );
endinterface

// File: rtl/busc_register_bank.sv
// Write side of the datapath register set: loads BUSC into any mix of
// PC/R1/R2/TR/R/AC/AR, with per-register increment and AC clear.
module busc_register_bank #(
  parameter int              DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  busc_register_bank_if.slave bus
);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] pc_q, r1_q, r2_q, tr_q, r_q, ac_q, ar_q;
  logic [DATA_W-1:0] pc_d, r1_d, r2_d, tr_d, r_d, ac_d, ar_d;
  logic              ac_z_q, ac_z_d;
  logic              wr_err_q, wr_err_d;
  logic              conflict;

  // Load beats clear beats increment; a load colliding with inc/clr is flagged.
  always_comb begin
    pc_d     = pc_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    tr_d     = tr_q;
    r_d      = r_q;
    ac_d     = ac_q;
    ar_d     = ar_q;
    ac_z_d   = ac_z_q;
    wr_err_d = wr_err_q;
    conflict = (bus.wrc[0] & bus.inc[0]) | (bus.wrc[1] & bus.inc[1]) |
               (bus.wrc[2] & bus.inc[2]) | (bus.wrc[4] & bus.inc[3]) |
               (bus.wrc[5] & bus.clr_ac);
    if (bus.en) begin
      if (bus.wrc[0])      pc_d = bus.busc;
      else if (bus.inc[0]) pc_d = pc_q + ONE;

      if (bus.wrc[1])      r1_d = bus.busc;
      else if (bus.inc[1]) r1_d = r1_q + ONE;

      if (bus.wrc[2])      r2_d = bus.busc;
      else if (bus.inc[2]) r2_d = r2_q + ONE;

      if (bus.wrc[3])      tr_d = bus.busc;

      if (bus.wrc[4])      r_d = bus.busc;
      else if (bus.inc[3]) r_d = r_q + ONE;

      if (bus.wrc[5])      ac_d = bus.busc;
      else if (bus.clr_ac) ac_d = '0;

      if (bus.wrc[6])      ar_d = bus.busc;

      ac_z_d   = (ac_d == '0);
      wr_err_d = wr_err_q | conflict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_RESET;
      r1_q     <= '0;
      r2_q     <= '0;
      tr_q     <= '0;
      r_q      <= '0;
      ac_q     <= '0;
      ar_q     <= '0;
      ac_z_q   <= 1'b1;
      wr_err_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      tr_q     <= tr_d;
      r_q      <= r_d;
      ac_q     <= ac_d;
      ar_q     <= ar_d;
      ac_z_q   <= ac_z_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.r1     = r1_q;
  assign bus.r2     = r2_q;
  assign bus.tr     = tr_q;
  assign bus.r      = r_q;
  assign bus.ac     = ac_q;
  assign bus.ar     = ar_q;
  assign bus.ac_z   = ac_z_q;
  assign bus.wr_err = wr_err_q;
endmodule
